// File: rtl/digit_seq_checker.sv
// Frames a DIGITS-long digit sequence, one digit per debounced step press,
// and compares it against EXPECTED while capturing.
module digit_seq_checker #(
  parameter int DIGITS = 7,
  parameter int DW = 4,
  parameter logic [DIGITS*DW-1:0] EXPECTED = 28'h3700592
) (
  input  logic                   clk,
  input  logic                   preset,
  input  logic                   step_in,
  input  logic [DW-1:0]          digit_in,
  input  logic                   clear,
  output logic [DIGITS*DW-1:0]   captured,
  output logic [3:0]             count,
  output logic                   busy,
  output logic                   done,
  output logic                   match,
  output logic                   err
);
  localparam int FW = DIGITS * DW;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t     state, next_state;
  logic       sync1, sync2, sync2_d, armed;
  logic [1:0] fill;
  logic       rise, first_cap, capture;
  logic [3:0] count_inc;

  function automatic logic [DW-1:0] exp_digit(input logic [3:0] idx);
    return DW'(EXPECTED >> (DW * (DIGITS - 1 - int'(idx))));
  endfunction

  // Step synchronizer. fill marks when sync2 reflects the real input, so a
  // switch held through reset must be seen low before arming.
  always_ff @(posedge clk) begin
    if (preset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sync1   <= step_in;
      sync2   <= sync1;
      sync2_d <= sync2;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && !sync2)
        armed <= 1'b1;
    end
  end

  assign rise      = sync2 & ~sync2_d & armed;
  assign count_inc = count + 4'd1;
  assign first_cap = (state == IDLE) && (digit_in != '0);
  assign capture   = rise && !clear && (first_cap || (state == CAPTURE));

  always_ff @(posedge clk) begin
    if (preset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear)
      next_state = IDLE;
    else if (capture) begin
      if (state == IDLE)
        next_state = (DIGITS == 1) ? DONE : CAPTURE;
      else if (count_inc == 4'(DIGITS))
        next_state = DONE;
    end
  end

  // Status decoded only from flops, so match changes on the same edge as done.
  always_comb begin
    busy  = (state == CAPTURE);
    done  = (state == DONE);
    match = (state == DONE) && !err;
  end

  always_ff @(posedge clk) begin
    if (preset || clear) begin
      captured <= '0;
      count    <= 4'd0;
      err      <= 1'b0;
    end else if (capture) begin
      captured <= (captured << DW) | FW'(digit_in);
      if (state == IDLE) begin
        count <= 4'd1;
        err   <= (digit_in != exp_digit(4'd0));
      end else begin
        count <= count_inc;
        err   <= err | (digit_in != exp_digit(count));
      end
    end
  end
endmodule

// File: tb/tb_digit_seq_checker.sv
// Bench for digit_seq_checker: vector table, hand-written corner sequences,
// and randomized presses against a queue-based frame model.
module tb_digit_seq_checker;
  localparam int DIGITS = 7;
  localparam int DW = 4;
  localparam logic [27:0] EXPECTED = 28'h3700592;
  localparam int OP_RESET = 0, OP_CLEAR = 1, OP_PRESS = 2;

  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic        step_in = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        clear = 1'b0;
  logic [27:0] captured;
  logic [3:0]  count;
  logic        busy, done, match, err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          op;
    logic [3:0]  dig;
    logic [27:0] cap;
    int          cnt;
    bit          dn;
    bit          er;
  } vec_t;

  vec_t tbl[$];
  int   q[$];

  digit_seq_checker #(.DIGITS(DIGITS), .DW(DW), .EXPECTED(EXPECTED)) dut (
    .clk(clk), .preset(preset), .step_in(step_in), .digit_in(digit_in),
    .clear(clear), .captured(captured), .count(count), .busy(busy),
    .done(done), .match(match), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [27:0] ecap, input int ecnt,
                           input bit edone, input bit eerr);
    chk({tag, " captured"}, 64'(captured), 64'(ecap));
    chk({tag, " count"},    64'(count),    64'(ecnt));
    chk({tag, " busy"},     64'(busy),     64'(ecnt != 0 && !edone));
    chk({tag, " done"},     64'(done),     64'(edone));
    chk({tag, " match"},    64'(match),    64'(edone && !eerr));
    chk({tag, " err"},      64'(err),      64'(eerr));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d, input int hi, input int lo);
    digit_in = d;
    step_in  = 1'b1;
    cyc(hi);
    step_in  = 1'b0;
    cyc(lo);
  endtask

  task automatic do_reset(input bit held);
    preset  = 1'b1;
    step_in = held;
    clear   = 1'b0;
    cyc(2);
    preset  = 1'b0;
    if (!held) cyc(5);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(2);
  endtask

  function automatic void add(input int op, input logic [3:0] d, input logic [27:0] cap,
                              input int cnt, input bit dn, input bit er);
    vec_t v;
    v.op = op; v.dig = d; v.cap = cap; v.cnt = cnt; v.dn = dn; v.er = er;
    tbl.push_back(v);
  endfunction

  // Reference: the frame is just the list of accepted digits.
  function automatic int exp_dig(input int i);
    longint p = 1;
    for (int k = 0; k < DIGITS - 1 - i; k++) p = p * 16;
    return int'((longint'(EXPECTED) / p) % 16);
  endfunction

  function automatic void model_event(input int d);
    if (q.size() == DIGITS) return;
    if (q.size() == 0 && d == 0) return;
    q.push_back(d);
  endfunction

  task automatic model_check(input string tag);
    longint v = 0;
    bit     e = 0;
    for (int i = 0; i < q.size(); i++) begin
      v = v * 16 + q[i];
      if (q[i] != exp_dig(i)) e = 1;
    end
    check_all(tag, v[27:0], q.size(), q.size() == DIGITS, e);
  endtask

  initial begin
    // Correct ID with leading zero, hold in DONE, clear, wrong digit,
    // clear, correct again, then a mid-frame reset.
    add(OP_RESET, 0, 28'h0, 0, 0, 0);
    add(OP_PRESS, 0, 28'h0, 0, 0, 0);
    add(OP_PRESS, 3, 28'h3, 1, 0, 0);
    add(OP_PRESS, 7, 28'h37, 2, 0, 0);
    add(OP_PRESS, 0, 28'h370, 3, 0, 0);
    add(OP_PRESS, 0, 28'h3700, 4, 0, 0);
    add(OP_PRESS, 5, 28'h37005, 5, 0, 0);
    add(OP_PRESS, 9, 28'h370059, 6, 0, 0);
    add(OP_PRESS, 2, 28'h3700592, 7, 1, 0);
    add(OP_PRESS, 4, 28'h3700592, 7, 1, 0);
    add(OP_PRESS, 1, 28'h3700592, 7, 1, 0);
    add(OP_PRESS, 8, 28'h3700592, 7, 1, 0);
    add(OP_CLEAR, 0, 28'h0, 0, 0, 0);
    add(OP_PRESS, 3, 28'h3, 1, 0, 0);
    add(OP_PRESS, 7, 28'h37, 2, 0, 0);
    add(OP_PRESS, 0, 28'h370, 3, 0, 0);
    add(OP_PRESS, 1, 28'h3701, 4, 0, 1);
    add(OP_PRESS, 5, 28'h37015, 5, 0, 1);
    add(OP_PRESS, 9, 28'h370159, 6, 0, 1);
    add(OP_PRESS, 2, 28'h3701592, 7, 1, 1);
    add(OP_PRESS, 6, 28'h3701592, 7, 1, 1);
    add(OP_CLEAR, 0, 28'h0, 0, 0, 0);
    add(OP_PRESS, 0, 28'h0, 0, 0, 0);
    add(OP_PRESS, 3, 28'h3, 1, 0, 0);
    add(OP_PRESS, 7, 28'h37, 2, 0, 0);
    add(OP_PRESS, 0, 28'h370, 3, 0, 0);
    add(OP_PRESS, 0, 28'h3700, 4, 0, 0);
    add(OP_PRESS, 5, 28'h37005, 5, 0, 0);
    add(OP_PRESS, 9, 28'h370059, 6, 0, 0);
    add(OP_PRESS, 2, 28'h3700592, 7, 1, 0);
    add(OP_RESET, 0, 28'h0, 0, 0, 0);
    add(OP_PRESS, 3, 28'h3, 1, 0, 0);
    add(OP_PRESS, 7, 28'h37, 2, 0, 0);
    add(OP_PRESS, 0, 28'h370, 3, 0, 0);
    add(OP_PRESS, 0, 28'h3700, 4, 0, 0);
    add(OP_RESET, 0, 28'h0, 0, 0, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_RESET: do_reset(1'b0);
        OP_CLEAR: clear_pulse();
        default:  press(tbl[i].dig, 2, 3);
      endcase
      check_all($sformatf("vec%0d", i), tbl[i].cap, tbl[i].cnt, tbl[i].dn, tbl[i].er);
    end

    // Latency: update lands on the third edge counting the first sample.
    do_reset(1'b0);
    digit_in = 4'd3;
    step_in  = 1'b1;
    cyc(1);
    chk("lat after E0 count", 64'(count), 64'd0);
    cyc(1);
    chk("lat after E1 count", 64'(count), 64'd0);
    cyc(1);
    chk("lat after E2 count", 64'(count), 64'd1);
    chk("lat after E2 captured", 64'(captured), 64'h3);
    step_in = 1'b0;
    cyc(3);

    // Switch held high through reset release.
    do_reset(1'b1);
    digit_in = 4'd3;
    cyc(8);
    chk("held high count", 64'(count), 64'd0);
    step_in = 1'b0;
    cyc(4);
    chk("held released count", 64'(count), 64'd0);
    step_in = 1'b1;
    cyc(3);
    step_in = 1'b0;
    cyc(3);
    check_all("held repress", 28'h3, 1, 0, 0);

    // clear colliding with a rise at count=3.
    do_reset(1'b0);
    press(3, 2, 3);
    press(7, 2, 3);
    press(0, 2, 3);
    check_all("pre collide", 28'h370, 3, 0, 0);
    digit_in = 4'd5;
    step_in  = 1'b1;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear   = 1'b0;
    step_in = 1'b0;
    cyc(4);
    check_all("collide", 28'h0, 0, 0, 0);
    press(3, 2, 3);
    check_all("after collide", 28'h3, 1, 0, 0);

    // Single-cycle glitch gives exactly one capture.
    do_reset(1'b0);
    press(3, 1, 6);
    check_all("glitch", 28'h3, 1, 0, 0);
    cyc(5);
    chk("glitch settled count", 64'(count), 64'd1);

    // Randomized presses, clears and resets against the frame model.
    do_reset(1'b0);
    q.delete();
    for (int n = 0; n < 250; n++) begin
      int r;
      int d;
      r = $urandom_range(0, 99);
      if (r < 6) begin
        clear_pulse();
        q.delete();
      end else if (r < 8) begin
        do_reset(1'b0);
        q.delete();
      end else begin
        if (q.size() < DIGITS && $urandom_range(0, 3) != 0)
          d = exp_dig(q.size());
        else
          d = $urandom_range(0, 15);
        press(4'(d), $urandom_range(1, 3), $urandom_range(2, 4));
        model_event(d);
      end
      model_check($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
